// File: rtl/fre_in_cond.sv
// ============================================================================
// Module      : fre_in_cond
// Description : Probe input conditioner. It synchronises and deglitches the
//               probe, then emits rise/fall pulses and a loss-of-signal flag.
//               Optional macro GLITCH_CNT_EN adds the glitch_cnt_o port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fre_in_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int LOS_CYC     = 50_000_000,
  parameter int LOS_W       = 26
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sig_i,
  output logic        sig_o,
  output logic        rise_o,
  output logic        fall_o,
  output logic        los_o
`ifdef GLITCH_CNT_EN
  ,
  output logic [15:0] glitch_cnt_o
`endif
);

  localparam int                FCNT_W      = $clog2(FILT_CYC) + 1;
  localparam logic [FCNT_W-1:0] c_FILT_LAST = FCNT_W'(FILT_CYC - 1);
  localparam logic [LOS_W-1:0]  c_LOS_LAST  = LOS_W'(LOS_CYC - 1);

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_PEND   = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     w_smp;
  logic                     r_lvl;
  logic [FCNT_W-1:0]        r_fcnt;
  logic [FCNT_W-1:0]        w_fcnt_nxt;
  logic                     w_flip;
  logic                     r_rise;
  logic                     r_fall;
  logic [LOS_W-1:0]         r_los_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_i};
    end
  end

  assign w_smp = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_STABLE;
      r_fcnt  <= '0;
      r_lvl   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_lvl   <= r_lvl ^ w_flip;
      r_rise  <= w_flip & ~r_lvl;
      r_fall  <= w_flip & r_lvl;
    end
  end

  // A level change is accepted only after FILT_CYC consecutive differing samples.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_flip      = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (w_smp != r_lvl) begin
          if (FILT_CYC == 1) begin
            w_flip = 1'b1;
          end else begin
            w_fcnt_nxt  = FCNT_W'(1);
            w_state_nxt = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (w_smp == r_lvl) begin
          w_fcnt_nxt  = '0;
          w_state_nxt = ST_STABLE;
        end else if (r_fcnt == c_FILT_LAST) begin
          w_flip      = 1'b1;
          w_fcnt_nxt  = '0;
          w_state_nxt = ST_STABLE;
        end else begin
          w_fcnt_nxt = r_fcnt + FCNT_W'(1);
        end
      end
      default: begin
        w_fcnt_nxt  = '0;
        w_state_nxt = ST_STABLE;
      end
    endcase
  end

  // The clear is keyed off the registered rise so los_o drops the cycle after rise_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_los_cnt <= '0;
    end else if (r_rise) begin
      r_los_cnt <= '0;
    end else if (r_los_cnt != c_LOS_LAST) begin
      r_los_cnt <= r_los_cnt + LOS_W'(1);
    end
  end

  assign sig_o  = r_lvl;
  assign rise_o = r_rise;
  assign fall_o = r_fall;
  assign los_o  = (r_los_cnt == c_LOS_LAST);

`ifdef GLITCH_CNT_EN
  logic        w_glitch;
  logic [15:0] r_glitch_cnt;

  assign w_glitch = (r_state == ST_PEND) && (w_smp == r_lvl);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_glitch_cnt <= '0;
    end else if (w_glitch && (r_glitch_cnt != 16'hFFFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 16'd1;
    end
  end

  assign glitch_cnt_o = r_glitch_cnt;
`endif

endmodule

`default_nettype wire
